// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending types, coin values and dispenser state encoding
//
// Purpose: common definitions for the change dispenser and its selector.
//   VAL50/VAL100/VAL500/VAL1000 : coin values in 50-won units
//   disp_state_t                : dispenser FSM states
//   denom_t                     : 2-bit denomination code (also the stock index)
//   coin_value()                : denomination code -> value in 50-won units
package vend_pkg;

  localparam logic [6:0] VAL50   = 7'd1;
  localparam logic [6:0] VAL100  = 7'd2;
  localparam logic [6:0] VAL500  = 7'd10;
  localparam logic [6:0] VAL1000 = 7'd20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_t;

  typedef enum logic [1:0] {
    DEN_50   = 2'd0,
    DEN_100  = 2'd1,
    DEN_500  = 2'd2,
    DEN_1000 = 2'd3
  } denom_t;

  function automatic logic [6:0] coin_value(input denom_t d);
    logic [6:0] v;
    case (d)
      DEN_50:   v = VAL50;
      DEN_100:  v = VAL100;
      DEN_500:  v = VAL500;
      DEN_1000: v = VAL1000;
      default:  v = VAL50;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/denom_select.sv
// rtl/denom_select.sv - greedy largest-first coin picker (combinational)
//
// Ports:
//   remain   in  7  balance still owed, 50-won units
//   in_stock in  4  per-denomination stock>0 flags, bit index = denom_t code
//   valid    out 1  some denomination fits remain and has stock
//   denom    out 2  chosen denomination (meaningful only when valid)
module denom_select
  import vend_pkg::*;
(
  input  logic [6:0] remain,
  input  logic [3:0] in_stock,
  output logic       valid,
  output denom_t     denom
);

  always_comb begin
    valid = 1'b0;
    denom = DEN_50;
    if (in_stock[3] && remain >= VAL1000) begin
      valid = 1'b1;
      denom = DEN_1000;
    end else if (in_stock[2] && remain >= VAL500) begin
      valid = 1'b1;
      denom = DEN_500;
    end else if (in_stock[1] && remain >= VAL100) begin
      valid = 1'b1;
      denom = DEN_100;
    end else if (in_stock[0] && remain >= VAL50) begin
      valid = 1'b1;
      denom = DEN_50;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out a balance coin by coin through the hopper
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   Load, Amount[6:0]     request to pay Amount (50-won units), taken only in IDLE
//   HopperReady           hopper accepts an eject pulse this cycle
//   Refill                reload all stocks to INIT_STOCK, taken only in IDLE
//   Eject50..Eject1000    one-cycle eject pulses, at most one high
//   Busy, Done            dispensing in progress / one-cycle completion pulse
//   Short, Residual[6:0]  last request not fully paid and its unpaid remainder
//   Stock50..Stock1000    live coin counts
module change_dispenser
  import vend_pkg::*;
#(
  parameter int STOCK_W    = 8,
  parameter int INIT_STOCK = 20,
  parameter int GAP        = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               Load,
  input  logic [6:0]         Amount,
  input  logic               HopperReady,
  input  logic               Refill,
  output logic               Eject50,
  output logic               Eject100,
  output logic               Eject500,
  output logic               Eject1000,
  output logic               Busy,
  output logic               Done,
  output logic               Short,
  output logic [6:0]         Residual,
  output logic [STOCK_W-1:0] Stock50,
  output logic [STOCK_W-1:0] Stock100,
  output logic [STOCK_W-1:0] Stock500,
  output logic [STOCK_W-1:0] Stock1000
);

  localparam int                 GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);

  disp_state_t        state, state_next;
  logic [6:0]         remain;
  denom_t             sel;
  logic [GAP_W-1:0]   gap_cnt;
  logic [STOCK_W-1:0] stock [4];

  logic [3:0] in_stock;
  logic       pick_valid;
  denom_t     pick;
  logic       load_ok, refill_ok, fire;

  always_comb begin
    in_stock = '0;
    for (int i = 0; i < 4; i++) in_stock[i] = (stock[i] != '0);
  end

  denom_select u_denom_select (
    .remain   (remain),
    .in_stock (in_stock),
    .valid    (pick_valid),
    .denom    (pick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ok    = 1'b0;
    refill_ok  = 1'b0;
    fire       = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ok   = Load;
        refill_ok = Refill;
        if (Load) state_next = ST_SELECT;
      end
      ST_SELECT: begin
        if (remain != '0 && pick_valid) state_next = ST_EJECT;
        else                            state_next = ST_DONE;
      end
      ST_EJECT: begin
        // The pulse itself is decoded combinationally from HopperReady,
        // so the bookkeeping must happen in exactly that cycle.
        if (HopperReady) begin
          fire       = 1'b1;
          state_next = (GAP == 0) ? ST_SELECT : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = ST_SELECT;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      remain   <= '0;
      sel      <= DEN_50;
      gap_cnt  <= '0;
      Short    <= 1'b0;
      Residual <= '0;
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_RST;
    end else begin
      if (load_ok) begin
        remain   <= Amount;
        Short    <= 1'b0;
        Residual <= '0;
      end
      // Refill shares the IDLE cycle with Load, so SELECT sees the new stock.
      if (refill_ok) begin
        for (int i = 0; i < 4; i++) stock[i] <= STOCK_RST;
      end
      if (state == ST_SELECT && remain != '0) begin
        if (pick_valid) begin
          sel <= pick;
        end else begin
          Short    <= 1'b1;
          Residual <= remain;
        end
      end
      // sel was only latched with value<=remain and stock>0, so neither wraps.
      if (fire) begin
        remain     <= remain - coin_value(sel);
        stock[sel] <= stock[sel] - STOCK_W'(1);
      end
      if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                 gap_cnt <= '0;
    end
  end

  assign Eject50   = (state == ST_EJECT) && HopperReady && (sel == DEN_50);
  assign Eject100  = (state == ST_EJECT) && HopperReady && (sel == DEN_100);
  assign Eject500  = (state == ST_EJECT) && HopperReady && (sel == DEN_500);
  assign Eject1000 = (state == ST_EJECT) && HopperReady && (sel == DEN_1000);
  assign Busy      = (state != ST_IDLE);
  assign Done      = (state == ST_DONE);
  assign Stock50   = stock[0];
  assign Stock100  = stock[1];
  assign Stock500  = stock[2];
  assign Stock1000 = stock[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       load   [2];
  logic       refill [2];
  logic       hr     [2];
  logic [6:0] amt    [2];
  wire  [3:0] ej     [2];
  wire        busy   [2];
  wire        done   [2];
  wire        short_o[2];
  wire  [6:0] resid  [2];
  wire  [7:0] stk    [2][4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lref   [2];
  int ms     [2][4];
  int init_v [2];
  int m_short[2];
  int m_resid[2];
  int exp_q0[$];
  int exp_q1[$];
  int tq0[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  change_dispenser #(.STOCK_W(8), .INIT_STOCK(20), .GAP(2)) u_dut (
    .CLK(CLK), .RST_N(rst_n), .Load(load[0]), .Amount(amt[0]),
    .HopperReady(hr[0]), .Refill(refill[0]),
    .Eject50(ej[0][0]), .Eject100(ej[0][1]), .Eject500(ej[0][2]), .Eject1000(ej[0][3]),
    .Busy(busy[0]), .Done(done[0]), .Short(short_o[0]), .Residual(resid[0]),
    .Stock50(stk[0][0]), .Stock100(stk[0][1]), .Stock500(stk[0][2]), .Stock1000(stk[0][3])
  );

  change_dispenser #(.STOCK_W(8), .INIT_STOCK(1), .GAP(2)) u_dut_low (
    .CLK(CLK), .RST_N(rst_n), .Load(load[1]), .Amount(amt[1]),
    .HopperReady(hr[1]), .Refill(refill[1]),
    .Eject50(ej[1][0]), .Eject100(ej[1][1]), .Eject500(ej[1][2]), .Eject1000(ej[1][3]),
    .Busy(busy[1]), .Done(done[1]), .Short(short_o[1]), .Residual(resid[1]),
    .Stock50(stk[1][0]), .Stock100(stk[1][1]), .Stock500(stk[1][2]), .Stock1000(stk[1][3])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Eject monitor: every pulse is popped against the scoreboard queue.
  always @(negedge CLK) begin : monitor
    int code;
    for (int i = 0; i < 2; i++) begin
      if (ej[i] != 4'd0) begin
        code = 0;
        for (int b = 0; b < 4; b++) if (ej[i][b]) code = b;
        check("eject_onehot", 32'($onehot(ej[i])), 1);
        check("eject_hopper_ready", 32'(hr[i]), 1);
        check("eject_stock_nonzero", 32'(stk[i][code] != 8'd0), 1);
        if (i == 0) begin
          tq0.push_back(cyc - lref[0]);
          if (exp_q0.size() == 0) check("unexpected_eject0", 32'(ej[i]), 0);
          else                    check("eject_order0", 32'(ej[i]), exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check("unexpected_eject1", 32'(ej[i]), 0);
          else                    check("eject_order1", 32'(ej[i]), exp_q1.pop_front());
        end
      end
    end
  end

  // Greedy reference: pushes expected one-hot eject codes and tracks stocks.
  task automatic model_load(input int i, input int a, input bit rf);
    int vals[4] = '{1, 2, 10, 20};
    int rem;
    bit found;
    if (rf) for (int d = 0; d < 4; d++) ms[i][d] = init_v[i];
    rem = a;
    for (int n = 0; n < 200 && rem > 0; n++) begin
      found = 1'b0;
      for (int d = 3; d >= 0; d--) begin
        if (!found && vals[d] <= rem && ms[i][d] > 0) begin
          found = 1'b1;
          if (i == 0) exp_q0.push_back(1 << d);
          else        exp_q1.push_back(1 << d);
          ms[i][d]--;
          rem -= vals[d];
        end
      end
      if (!found) break;
    end
    m_short[i] = (rem > 0) ? 1 : 0;
    m_resid[i] = rem;
  endtask

  task automatic drive_load(input int i, input int a, input bit rf);
    @(posedge CLK); #1;
    load[i] = 1'b1; amt[i] = 7'(a); refill[i] = rf; lref[i] = cyc;
    @(posedge CLK); #1;
    load[i] = 1'b0; refill[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int rel);
    rel = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (done[i]) begin
        rel = cyc - lref[i];
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic check_result(input int i);
    check("short", 32'(short_o[i]), m_short[i]);
    check("residual", 32'(resid[i]), m_resid[i]);
    for (int d = 0; d < 4; d++) check("stock", 32'(stk[i][d]), ms[i][d]);
    check("queue_drained", (i == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic run_load(input int i, input int a, input bit rf, output int rel);
    model_load(i, a, rf);
    if (i == 0) tq0.delete();
    drive_load(i, a, rf);
    wait_done(i, rel);
    check_result(i);
  endtask

  initial begin : stim
    int rel;
    init_v[0] = 20; init_v[1] = 1;
    for (int i = 0; i < 2; i++) begin
      load[i] = 1'b0; refill[i] = 1'b0; hr[i] = 1'b1; amt[i] = '0; lref[i] = 0;
      for (int d = 0; d < 4; d++) ms[i][d] = init_v[i];
    end
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_eject", 32'(ej[i]), 0);
      check("rst_busy", 32'(busy[i]), 0);
      check("rst_done", 32'(done[i]), 0);
      check("rst_short", 32'(short_o[i]), 0);
      check("rst_residual", 32'(resid[i]), 0);
      for (int d = 0; d < 4; d++) check("rst_stock", 32'(stk[i][d]), init_v[i]);
    end

    // Amount 37 with full stock: 1000,500,100,100,100,50 spaced GAP+2
    run_load(0, 37, 0, rel);
    check("t1_stock50", 32'(stk[0][0]), 19);
    check("t1_stock100", 32'(stk[0][1]), 17);
    check("t1_stock500", 32'(stk[0][2]), 19);
    check("t1_stock1000", 32'(stk[0][3]), 19);
    check("t1_eject_count", tq0.size(), 6);
    if (tq0.size() == 6) begin
      check("t1_first_eject", tq0[0], 2);
      for (int k = 1; k < 6; k++) check("t1_spacing", tq0[k] - tq0[k-1], 4);
    end
    check("t1_done_cycle", rel, 26);

    // INIT_STOCK=1 instance: partial payment
    run_load(1, 40, 0, rel);
    check("t2_short", 32'(short_o[1]), 1);
    check("t2_residual", 32'(resid[1]), 7);
    for (int d = 0; d < 4; d++) check("t2_stock_empty", 32'(stk[1][d]), 0);

    // HopperReady low through the first five EJECT cycles
    model_load(0, 3, 0);
    tq0.delete();
    @(posedge CLK); #1;
    load[0] = 1'b1; amt[0] = 7'd3; hr[0] = 1'b0; lref[0] = cyc;
    @(posedge CLK); #1;
    load[0] = 1'b0;
    repeat (6) @(posedge CLK);
    #1 hr[0] = 1'b1;
    wait_done(0, rel);
    check_result(0);
    check("t3_eject_count", tq0.size(), 2);
    if (tq0.size() == 2) begin
      check("t3_first_eject", tq0[0], 7);
      check("t3_second_eject", tq0[1], 11);
    end
    check("t3_done_cycle", rel, 15);

    // Amount 0: Done at cycle 2, IDLE at cycle 3
    model_load(0, 0, 0);
    drive_load(0, 0, 0);
    @(negedge CLK);
    check("t4_busy_c1", 32'(busy[0]), 1);
    check("t4_done_c1", 32'(done[0]), 0);
    @(negedge CLK);
    check("t4_done_c2", 32'(done[0]), 1);
    check("t4_short", 32'(short_o[0]), 0);
    check("t4_residual", 32'(resid[0]), 0);
    @(negedge CLK);
    check("t4_busy_c3", 32'(busy[0]), 0);
    check("t4_done_c3", 32'(done[0]), 0);
    check("t4_queue", exp_q0.size(), 0);

    // Load+Refill while busy are ignored; reset after the second eject aborts
    exp_q0.push_back(8); exp_q0.push_back(4);
    ms[0][3]--; ms[0][2]--;
    tq0.delete();
    drive_load(0, 37, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    load[0] = 1'b1; amt[0] = 7'd5; refill[0] = 1'b1;
    @(posedge CLK); #1;
    load[0] = 1'b0; refill[0] = 1'b0;
    @(negedge CLK);
    check("t5_no_refill", 32'(stk[0][3]), ms[0][3]);
    check("t5_busy", 32'(busy[0]), 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check("t5_busy_after_rst", 32'(busy[0]), 0);
    for (int d = 0; d < 4; d++) check("t5_stock_rst", 32'(stk[0][d]), 20);
    check("t5_queue", exp_q0.size(), 0);
    check("t5_eject_count", tq0.size(), 2);
    if (tq0.size() == 2) check("t5_second_eject", tq0[1], 6);
    repeat (10) @(negedge CLK);
    for (int i = 0; i < 2; i++) for (int d = 0; d < 4; d++) ms[i][d] = init_v[i];

    // Drain with 40-unit loads until short, then Refill+Load 21 together
    for (int n = 0; n < 30; n++) begin
      run_load(0, 40, 0, rel);
      if (m_short[0] != 0) break;
    end
    check("t6_drained_short", 32'(short_o[0]), 1);
    check("t6_drained_residual", 32'(resid[0]), 20);
    run_load(0, 21, 1, rel);
    check("t6_short", 32'(short_o[0]), 0);
    check("t6_stock1000", 32'(stk[0][3]), 19);
    check("t6_stock50", 32'(stk[0][0]), 19);
    check("t6_stock100", 32'(stk[0][1]), 20);

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin change/refund dispenser sitting directly downstream of the vending controller. When the controller finishes a sale or the customer presses Return, it hands the remaining balance here as a single load. This block pays the balance out coin by coin through the hopper, using greedy largest-first selection limited by per-denomination stock. It reports completion, any shortfall it could not pay, and the live stock counts.

## Interface
Parameters:
- STOCK_W, 8, width of each per-denomination stock counter
- INIT_STOCK, 20, stock loaded into every denomination on reset and on Refill
- GAP, 2, idle cycles enforced after each eject pulse (0 allowed)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- Load  in  1  one-cycle request to dispense Amount; honoured only in IDLE
- Amount  in  7  balance to pay, in 50-won units (0..127 = 0..6350 won)
- HopperReady  in  1  hopper can accept an eject pulse this cycle
- Refill  in  1  set all four stocks to INIT_STOCK; honoured only in IDLE
- Eject50 / Eject100 / Eject500 / Eject1000  out  1 each  one-cycle eject pulse to the hopper
- Busy  out  1  high from the cycle after an accepted Load until DONE exits
- Done  out  1  one-cycle completion pulse
- Short  out  1  last request could not be paid in full; held until next accepted Load
- Residual  out  7  unpaid remainder of last request, 50-won units; held until next accepted Load
- Stock50 / Stock100 / Stock500 / Stock1000  out  STOCK_W each  current coin counts

## Operation
- Coin values in 50-won units: 50→1, 100→2, 500→10, 1000→20. Remain is a 7-bit register.
- States and transitions:
  - IDLE: Load → Remain<=Amount, Short<=0, Residual<=0, go to SELECT.
  - SELECT: if Remain==0 → DONE. Otherwise pick the largest denomination with value≤Remain and stock>0, latch it, go to EJECT. If no denomination qualifies → Short<=1, Residual<=Remain, go to DONE.
  - EJECT: wait while HopperReady=0, with no pulse. In the first cycle with HopperReady=1: assert the selected Eject pulse, Remain-=value, stock-=1, then go to GAP, or to SELECT if GAP==0.
  - GAP: count GAP cycles, then go to SELECT.
  - DONE: Done=1 for one cycle, then go to IDLE.
- At most one Eject output is high in any cycle. An eject never fires with stock 0. Remain never underflows.
- Load or Refill while Busy: ignored entirely, with no side effect.
- Load and Refill in the same IDLE cycle: both take effect. SELECT sees the refilled stock.
- Amount=0: no ejects, Short=0.
- Stock counters saturate at 0, because decrement is guarded by the stock>0 selection. Refill overwrites; it does not add.

## Timing
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE.
  - All Eject outputs, Busy, Done, Short = 0; Residual = 0; Remain = 0.
  - All stocks = INIT_STOCK.
- Reset mid-dispense aborts immediately. No further pulses are issued, and coins already ejected are not restored.
- Load sampled at edge 0:
  - SELECT at cycle 1.
  - Earliest eject pulse at cycle 2.
  - Busy high cycles 1 through the DONE cycle.
- Back-to-back ejects with HopperReady held high are spaced exactly GAP+2 cycles apart (EJECT, GAP×GAP, SELECT).
- Amount=0: Done high at cycle 2; IDLE at cycle 3.
- Outputs are registered or decoded from registered state only. HopperReady is the only input that affects a same-cycle output (the eject pulse).

## Structure
- Shared package vend_pkg holds:
  - coin value constants (VAL50=1, VAL100=2, VAL500=10, VAL1000=20)
  - the dispenser state enum (IDLE, SELECT, EJECT, GAP, DONE)
  - a 2-bit denomination code
- Sub-module denom_select: purely combinational. Inputs are Remain and the four stock>0 flags. Outputs are a valid bit and the chosen denomination code. The FSM, counters and stocks stay in change_dispenser.

## Test plan
- Reset, Load Amount=37, HopperReady=1, GAP=2 → Eject1000, 500, 100, 100, 100, 50, in that order, each 4 cycles apart; Done with Short=0; stocks 19/17/19/19 (50/100/500/1000 order).
- INIT_STOCK=1, Load Amount=40 → Eject1000, Eject500, Eject100, Eject50 only; Short=1, Residual=7; all stocks 0.
- HopperReady held low for 5 cycles during the first EJECT → no pulse while low; exactly one one-cycle pulse in the first cycle Ready=1.
- Load Amount=0 → no ejects; Done at cycle 2; Short=0, Residual=0.
- Second Load and a Refill issued mid-dispense → both ignored and Remain unaffected. RST_N=0 after the second eject → no further pulses, Busy=0, stocks back to INIT_STOCK.
- After draining stock (40-unit loads until Short), Refill plus Load Amount=21 in the same cycle → Eject1000, Eject50; Short=0.
